rcv_ctrl_fsm: RTL and testbench
===============================

RCV_CTRL_FSM -- requirements
Module: rcv_ctrl_fsm

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'h80, the required first byte of every packet.
REQ-002 SHALL have parameter MAX_BYTES, default 64, the maximum number of data bytes per packet.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 n_rst  in  1  asynchronous reset, active-low.
REQ-005 d_edge  in  1  one-cycle pulse marking a bus transition.
REQ-006 shift_enable  in  1  one-cycle bit-sample strobe from the receive timer.
REQ-007 eop  in  1  end-of-packet line state; valid only when shift_enable=1.
REQ-008 byte_received  in  1  one-cycle pulse from the receive timer when 8 bits have been shifted.
REQ-009 rcv_data  in  8  shift-register byte; stable on the cycle byte_received=1 and the following cycle.
REQ-010 rcving  out  1  drives the timer's transfer_active; high while a packet is being received.
REQ-011 w_enable  out  1  one-cycle FIFO write strobe for a data byte.
REQ-012 r_error  out  1  sticky receive-error flag.
REQ-013 rx_pid  out  4  PID of the last packet that passed the PID check.
REQ-014 byte_count  out  7  number of data bytes written in the current packet.
REQ-015 packet_done  out  1  one-cycle pulse when a packet ends cleanly.

Function
REQ-016 SHALL implement the states IDLE, SYNC_WAIT, SYNC_CHK, PID_WAIT, PID_CHK, DATA_WAIT, DATA_STORE, EOP_WAIT, ERR_WAIT and ERR_IDLE.
REQ-017 "eop_hit" SHALL mean eop=1 and shift_enable=1 on the same cycle.
REQ-018 IDLE: on d_edge -> SYNC_WAIT; clear r_error and byte_count on that cycle.
REQ-019 SYNC_WAIT: eop_hit -> ERR_IDLE with r_error set; else on byte_received -> SYNC_CHK.
REQ-020 SYNC_CHK (one cycle): rcv_data==SYNC_BYTE -> PID_WAIT; otherwise -> ERR_WAIT with r_error set.
REQ-021 PID_WAIT: eop_hit -> ERR_IDLE with r_error set; else on byte_received -> PID_CHK.
REQ-022 PID_CHK (one cycle): rcv_data[7:4]==~rcv_data[3:0] -> latch rx_pid<=rcv_data[3:0] and go to DATA_WAIT; otherwise -> ERR_WAIT with r_error set and rx_pid unchanged.
REQ-023 DATA_WAIT: eop_hit -> EOP_WAIT (clean end, including zero data bytes); else on byte_received -> DATA_STORE.
REQ-024 DATA_STORE (one cycle):
- byte_count<MAX_BYTES: w_enable=1, byte_count increments, next state DATA_WAIT.
- byte_count==MAX_BYTES: w_enable=0, byte_count holds, r_error set, next state ERR_WAIT.
REQ-025 EOP_WAIT: on d_edge -> IDLE with packet_done=1 for exactly that transition cycle.
REQ-026 ERR_WAIT: on eop_hit -> ERR_IDLE; byte_received is ignored.
REQ-027 ERR_IDLE: on d_edge -> IDLE; packet_done SHALL NOT assert.
REQ-028 In any WAIT state, if eop_hit and byte_received coincide, eop_hit SHALL take priority.
REQ-029 rcving SHALL be 1 in SYNC_WAIT through DATA_STORE and in ERR_WAIT, and 0 in IDLE, EOP_WAIT and ERR_IDLE.
REQ-030 w_enable and packet_done SHALL be Moore/registered and glitch-free, and SHALL never assert in the same cycle.
REQ-031 r_error SHALL remain set until the next IDLE->SYNC_WAIT transition.
REQ-032 byte_count SHALL saturate at MAX_BYTES and SHALL never wrap.

Reset
REQ-033 n_rst=0 SHALL immediately force state=IDLE, rcving=0, w_enable=0, r_error=0, rx_pid=4'h0, byte_count=0 and packet_done=0, including mid-packet.
REQ-034 After n_rst deasserts, the first d_edge SHALL start a packet normally.

Verification
REQ-035 Good packet: d_edge, then bytes 8'h80, 8'hD2 (PID 2), 8'h11, 8'h22, then eop_hit and d_edge -> rx_pid=2, two w_enable pulses, byte_count=2, packet_done=1 once, r_error=0.
REQ-036 Bad sync: first byte 8'h81 -> r_error=1 and no w_enable; after eop_hit and d_edge -> state IDLE, packet_done=0.
REQ-037 Bad PID: sync 8'h80, then PID byte 8'h32 -> r_error=1, rx_pid keeps its prior value, no w_enable.
REQ-038 Overflow with MAX_BYTES=64: 65 data bytes -> exactly 64 w_enable pulses, byte_count=64, r_error=1 on the 65th byte.
REQ-039 Coincidence: in DATA_WAIT, eop_hit on the same cycle as byte_received -> EOP_WAIT with no w_enable; early eop_hit in SYNC_WAIT -> r_error=1.
REQ-040 Reset mid-packet: assert n_rst during DATA_WAIT after 3 bytes -> all outputs 0 immediately; the next packet is received correctly.

Source files
------------

// File: rtl/rcv_ctrl_fsm.sv
// Receive-side packet control FSM: sync/PID checks, data byte strobes,
// error tracking and clean end-of-packet detection.
//
// Ports:
//   clk, n_rst        clock, async active-low reset
//   d_edge            one-cycle bus transition pulse
//   shift_enable      bit-sample strobe from the receive timer
//   eop               end-of-packet line state (qualified by shift_enable)
//   byte_received     one-cycle pulse when 8 bits are shifted in
//   rcv_data[7:0]     received byte from the shift register
//   rcving            high while a packet is in progress
//   w_enable          one-cycle FIFO write strobe for a data byte
//   r_error           sticky receive-error flag
//   rx_pid[3:0]       PID of the last packet that passed the PID check
//   byte_count[6:0]   data bytes written in the current packet
//   packet_done       one-cycle pulse on a clean packet end
module rcv_ctrl_fsm #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       shift_enable,
    input  logic       eop,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error,
    output logic [3:0] rx_pid,
    output logic [6:0] byte_count,
    output logic       packet_done
);

    typedef enum logic [3:0] {
        IDLE,
        SYNC_WAIT,
        SYNC_CHK,
        PID_WAIT,
        PID_CHK,
        DATA_WAIT,
        DATA_STORE,
        EOP_WAIT,
        ERR_WAIT,
        ERR_IDLE
    } state_t;

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    state_t     state;
    state_t     state_n;
    logic       rcving_n;
    logic       wen_n;
    logic       err_n;
    logic [3:0] pid_n;
    logic [6:0] cnt_n;
    logic       done_n;

    logic eop_hit;
    logic pid_ok;
    logic room;

    assign eop_hit = eop & shift_enable;
    assign pid_ok  = (rcv_data[7:4] == ~rcv_data[3:0]);
    assign room    = (byte_count < MAX_CNT);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            rcving      <= 1'b0;
            w_enable    <= 1'b0;
            r_error     <= 1'b0;
            rx_pid      <= 4'h0;
            byte_count  <= 7'd0;
            packet_done <= 1'b0;
        end else begin
            state       <= state_n;
            rcving      <= rcving_n;
            w_enable    <= wen_n;
            r_error     <= err_n;
            rx_pid      <= pid_n;
            byte_count  <= cnt_n;
            packet_done <= done_n;
        end
    end

    // Outputs are computed from the next state and registered, so each
    // one changes cleanly on the clock edge that enters its state.
    always_comb begin
        state_n = state;
        wen_n   = 1'b0;
        err_n   = r_error;
        pid_n   = rx_pid;
        cnt_n   = byte_count;
        done_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (d_edge) begin
                    state_n = SYNC_WAIT;
                    err_n   = 1'b0;
                    cnt_n   = 7'd0;
                end
            end
            SYNC_WAIT: begin
                if (eop_hit) begin
                    state_n = ERR_IDLE;
                    err_n   = 1'b1;
                end else if (byte_received) begin
                    state_n = SYNC_CHK;
                end
            end
            SYNC_CHK: begin
                if (rcv_data == SYNC_BYTE) begin
                    state_n = PID_WAIT;
                end else begin
                    state_n = ERR_WAIT;
                    err_n   = 1'b1;
                end
            end
            PID_WAIT: begin
                if (eop_hit) begin
                    state_n = ERR_IDLE;
                    err_n   = 1'b1;
                end else if (byte_received) begin
                    state_n = PID_CHK;
                end
            end
            PID_CHK: begin
                if (pid_ok) begin
                    state_n = DATA_WAIT;
                    pid_n   = rcv_data[3:0];
                end else begin
                    state_n = ERR_WAIT;
                    err_n   = 1'b1;
                end
            end
            DATA_WAIT: begin
                if (eop_hit) begin
                    state_n = EOP_WAIT;
                end else if (byte_received) begin
                    state_n = DATA_STORE;
                    // Strobe lands in DATA_STORE only when there is room.
                    wen_n   = room;
                end
            end
            DATA_STORE: begin
                if (room) begin
                    state_n = DATA_WAIT;
                    cnt_n   = byte_count + 7'd1;
                end else begin
                    state_n = ERR_WAIT;
                    err_n   = 1'b1;
                end
            end
            EOP_WAIT: begin
                if (d_edge) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            ERR_WAIT: begin
                if (eop_hit) begin
                    state_n = ERR_IDLE;
                end
            end
            ERR_IDLE: begin
                if (d_edge) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        rcving_n = state_n inside {SYNC_WAIT, SYNC_CHK, PID_WAIT,
                                   PID_CHK, DATA_WAIT, DATA_STORE,
                                   ERR_WAIT};
    end

endmodule

// File: tb/tb_rcv_ctrl_fsm.sv
// Scoreboard testbench for rcv_ctrl_fsm: expected data bytes are queued
// as they are sent and matched against each w_enable strobe.
module tb_rcv_ctrl_fsm;

    logic       clk;
    logic       n_rst;
    logic       d_edge;
    logic       shift_enable;
    logic       eop;
    logic       byte_received;
    logic [7:0] rcv_data;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
    logic [3:0] rx_pid;
    logic [6:0] byte_count;
    logic       packet_done;

    int n_chk  = 0;
    int n_pass = 0;
    int w_cnt  = 0;
    int d_cnt  = 0;
    int pushed = 0;
    logic [7:0] data_q[$];

    rcv_ctrl_fsm #(
        .SYNC_BYTE(8'h80),
        .MAX_BYTES(64)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_edge       (d_edge),
        .shift_enable (shift_enable),
        .eop          (eop),
        .byte_received(byte_received),
        .rcv_data     (rcv_data),
        .rcving       (rcving),
        .w_enable     (w_enable),
        .r_error      (r_error),
        .rx_pid       (rx_pid),
        .byte_count   (byte_count),
        .packet_done  (packet_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard side: every write strobe must match the next queued byte.
    always @(posedge clk) begin
        #1;
        if (w_enable === 1'b1) begin
            w_cnt++;
            if (data_q.size() == 0) chk("wen_unexpected", 1, 0);
            else chk("wdata", rcv_data, data_q.pop_front());
        end
        if (packet_done === 1'b1) d_cnt++;
        if (w_enable === 1'b1 || packet_done === 1'b1)
            chk("wen_done_excl", w_enable & packet_done, 0);
    end

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic edge_pulse();
        @(negedge clk);
        d_edge = 1'b1;
        @(negedge clk);
        d_edge = 1'b0;
        gap(1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit is_data);
        if (is_data) begin
            data_q.push_back(b);
            pushed++;
        end
        @(negedge clk);
        rcv_data      = b;
        byte_received = 1'b1;
        @(negedge clk);
        byte_received = 1'b0;
        gap(2);
    endtask

    task automatic eop_pulse(input bit with_byte, input logic [7:0] b);
        @(negedge clk);
        eop          = 1'b1;
        shift_enable = 1'b1;
        if (with_byte) begin
            rcv_data      = b;
            byte_received = 1'b1;
        end
        @(negedge clk);
        eop           = 1'b0;
        shift_enable  = 1'b0;
        byte_received = 1'b0;
        gap(2);
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_rcving"}, rcving, 0);
        chk({tag, "_wen"}, w_enable, 0);
        chk({tag, "_rerr"}, r_error, 0);
        chk({tag, "_pid"}, rx_pid, 0);
        chk({tag, "_cnt"}, byte_count, 0);
        chk({tag, "_done"}, packet_done, 0);
    endtask

    initial begin
        int w0;
        int d0;
        n_rst         = 1'b0;
        d_edge        = 1'b0;
        shift_enable  = 1'b0;
        eop           = 1'b0;
        byte_received = 1'b0;
        rcv_data      = 8'h00;
        gap(3);
        outs_zero("rst");
        n_rst = 1'b1;
        gap(2);

        // Good packet, PID 2, two data bytes
        w0 = w_cnt; d0 = d_cnt;
        edge_pulse();
        chk("good_rcving", rcving, 1);
        send_byte(8'h80, 0);
        send_byte(8'hD2, 0);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        eop_pulse(0, 8'h00);
        chk("good_eop_rcving", rcving, 0);
        chk("good_pre_done", d_cnt - d0, 0);
        edge_pulse();
        chk("good_pid", rx_pid, 2);
        chk("good_cnt", byte_count, 2);
        chk("good_wen", w_cnt - w0, 2);
        chk("good_done", d_cnt - d0, 1);
        chk("good_rerr", r_error, 0);

        // Bad sync byte; later bytes ignored until eop
        w0 = w_cnt; d0 = d_cnt;
        edge_pulse();
        send_byte(8'h81, 0);
        chk("bsync_rerr", r_error, 1);
        chk("bsync_rcving", rcving, 1);
        send_byte(8'h55, 0);
        eop_pulse(0, 8'h00);
        chk("bsync_erridle_rcv", rcving, 0);
        edge_pulse();
        chk("bsync_wen", w_cnt - w0, 0);
        chk("bsync_done", d_cnt - d0, 0);
        chk("bsync_sticky", r_error, 1);
        chk("bsync_pid_keep", rx_pid, 2);

        // Bad PID: prior PID must survive
        w0 = w_cnt; d0 = d_cnt;
        edge_pulse();
        chk("bpid_err_clr", r_error, 0);
        send_byte(8'h80, 0);
        send_byte(8'h32, 0);
        chk("bpid_rerr", r_error, 1);
        chk("bpid_pid_keep", rx_pid, 2);
        eop_pulse(0, 8'h00);
        edge_pulse();
        chk("bpid_wen", w_cnt - w0, 0);
        chk("bpid_done", d_cnt - d0, 0);

        // Overflow: 65 data bytes, only 64 written
        w0 = w_cnt; d0 = d_cnt;
        edge_pulse();
        send_byte(8'h80, 0);
        send_byte(8'hA5, 0);
        chk("ovf_pid", rx_pid, 5);
        for (int i = 0; i < 64; i++) send_byte(8'(i + 1), 1);
        chk("ovf_cnt64", byte_count, 64);
        chk("ovf_noerr64", r_error, 0);
        send_byte(8'hEE, 0);
        chk("ovf_rerr", r_error, 1);
        chk("ovf_cnt_sat", byte_count, 64);
        chk("ovf_wen", w_cnt - w0, 64);
        eop_pulse(0, 8'h00);
        edge_pulse();
        chk("ovf_done", d_cnt - d0, 0);

        // eop_hit and byte_received together in DATA_WAIT
        w0 = w_cnt; d0 = d_cnt;
        edge_pulse();
        send_byte(8'h80, 0);
        send_byte(8'hE1, 0);
        send_byte(8'h33, 1);
        eop_pulse(1, 8'h44);
        chk("coin_rcving", rcving, 0);
        chk("coin_cnt", byte_count, 1);
        chk("coin_rerr", r_error, 0);
        edge_pulse();
        chk("coin_wen", w_cnt - w0, 1);
        chk("coin_done", d_cnt - d0, 1);
        chk("coin_pid", rx_pid, 1);

        // Early eop in SYNC_WAIT
        d0 = d_cnt;
        edge_pulse();
        eop_pulse(0, 8'h00);
        chk("early_rerr", r_error, 1);
        chk("early_rcving", rcving, 0);
        edge_pulse();
        chk("early_done", d_cnt - d0, 0);

        // Reset mid-packet after three data bytes
        edge_pulse();
        send_byte(8'h80, 0);
        send_byte(8'hD2, 0);
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        send_byte(8'h03, 1);
        chk("mid_cnt3", byte_count, 3);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1 outs_zero("midrst");
        @(negedge clk);
        n_rst = 1'b1;
        gap(2);

        w0 = w_cnt; d0 = d_cnt;
        edge_pulse();
        send_byte(8'h80, 0);
        send_byte(8'hC3, 0);
        send_byte(8'h5A, 1);
        send_byte(8'hA5, 1);
        eop_pulse(0, 8'h00);
        edge_pulse();
        chk("post_pid", rx_pid, 3);
        chk("post_cnt", byte_count, 2);
        chk("post_wen", w_cnt - w0, 2);
        chk("post_done", d_cnt - d0, 1);
        chk("post_rerr", r_error, 0);

        gap(3);
        chk("sb_empty", data_q.size(), 0);
        chk("sb_total", w_cnt, pushed);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
